// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Load/store unit between a processor request port and a single-port word RAM
// with one cycle of read latency. Sub-word stores are done as read-modify-write
// so the RAM only ever sees whole-word writes. Lanes are little-endian.
module data_mem_ctrl #(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misaligned,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // FSM encoding
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] CAP  = 3'd2;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   // Access sizes
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // True when the size/offset pair cannot be served as a single lane access.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic result;
      case (size)
         SIZE_BYTE: result = 1'b0;
         SIZE_HALF: result = addrLo[0];
         SIZE_WORD: result = (addrLo != 2'b00);
         default:   result = 1'b1;
      endcase
      return result;
   endfunction

   // Pull the addressed lane out of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  addrLo,
                                               input logic        zeroExt);
      logic [7:0]  laneByte;
      logic [15:0] laneHalf;
      logic [31:0] result;
      case (addrLo)
         2'd0:    laneByte = word[7:0];
         2'd1:    laneByte = word[15:8];
         2'd2:    laneByte = word[23:16];
         2'd3:    laneByte = word[31:24];
         default: laneByte = 8'h00;
      endcase
      laneHalf = addrLo[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: result = zeroExt ? {24'h000000, laneByte} : {{24{laneByte[7]}}, laneByte};
         SIZE_HALF: result = zeroExt ? {16'h0000, laneHalf}   : {{16{laneHalf[15]}}, laneHalf};
         SIZE_WORD: result = word;
         default:   result = 32'h00000000;
      endcase
      return result;
   endfunction

   // Replace only the addressed lane of an old RAM word with new store data.
   function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                              input logic [15:0] laneData,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addrLo);
      logic [31:0] result;
      result = word;
      case (size)
         SIZE_BYTE: begin
            case (addrLo)
               2'd0:    result[7:0]   = laneData[7:0];
               2'd1:    result[15:8]  = laneData[7:0];
               2'd2:    result[23:16] = laneData[7:0];
               2'd3:    result[31:24] = laneData[7:0];
               default: result        = word;
            endcase
         end
         SIZE_HALF: begin
            if (addrLo[1]) begin
               result[31:16] = laneData;
            end else begin
               result[15:0] = laneData;
            end
         end
         default: result = word;
      endcase
      return result;
   endfunction

   logic [2:0]        stateR;
   logic [2:0]        nextStateS;
   logic [1:0]        addrLoR;
   logic [1:0]        sizeR;
   logic              writeR;
   logic              unsignedR;
   logic [15:0]       storeLaneR;
   logic [ADDR_W-1:0] memAddrR;
   logic [31:0]       memWdataR;
   logic [31:0]       memWdataNextS;
   logic              memWeR;
   logic              respValidR;
   logic              misalignedR;
   logic [31:0]       respRdataR;
   logic [31:0]       respRdataNextS;
   logic              acceptS;
   logic              reqMisS;
   logic              reqWordStoreS;

   assign acceptS       = req_valid && (stateR == IDLE);
   assign reqMisS       = isMisaligned(req_size, req_addr[1:0]);
   assign reqWordStoreS = req_write && (req_size == SIZE_WORD);

   // Address bits above the RAM window are intentionally dropped (wrap-around).
   if (ADDR_W < 32) begin : gDroppedAddr
      logic unusedAddrS;
      assign unusedAddrS = ^req_addr[31:ADDR_W];
   end

   // Next-state selection for the access sequencer.
   always_comb begin
      nextStateS = stateR;
      case (stateR)
         IDLE: begin
            if (acceptS) begin
               if (reqMisS) begin
                  nextStateS = RESP;
               end else if (reqWordStoreS) begin
                  nextStateS = WR;
               end else begin
                  nextStateS = RD;
               end
            end else begin
               nextStateS = IDLE;
            end
         end
         RD:   nextStateS = CAP;
         CAP: begin
            if (writeR) begin
               nextStateS = WR;
            end else begin
               nextStateS = RESP;
            end
         end
         WR:   nextStateS = RESP;
         RESP: nextStateS = IDLE;
         default: nextStateS = IDLE;
      endcase
   end

   // Next values of the RAM write word and the load response word.
   always_comb begin
      memWdataNextS  = memWdataR;
      respRdataNextS = 32'h00000000;
      if (acceptS && reqWordStoreS && !reqMisS) begin
         memWdataNextS = req_wdata;
      end else if ((stateR == CAP) && writeR) begin
         memWdataNextS = mergeStore(mem_rdata, storeLaneR, sizeR, addrLoR);
      end else begin
         memWdataNextS = memWdataR;
      end
      if ((stateR == CAP) && !writeR) begin
         respRdataNextS = extractLoad(mem_rdata, sizeR, addrLoR, unsignedR);
      end else begin
         respRdataNextS = 32'h00000000;
      end
   end

   // State, captured request fields and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateR      <= IDLE;
         addrLoR     <= 2'b00;
         sizeR       <= 2'b00;
         writeR      <= 1'b0;
         unsignedR   <= 1'b0;
         storeLaneR  <= 16'h0000;
         memAddrR    <= '0;
         memWdataR   <= 32'h00000000;
         memWeR      <= 1'b0;
         respValidR  <= 1'b0;
         misalignedR <= 1'b0;
         respRdataR  <= 32'h00000000;
      end else begin
         stateR <= nextStateS;
         if (acceptS) begin
            addrLoR    <= req_addr[1:0];
            sizeR      <= req_size;
            writeR     <= req_write;
            unsignedR  <= req_unsigned;
            storeLaneR <= req_wdata[15:0];
            memAddrR   <= {req_addr[ADDR_W-1:2], 2'b00};
         end
         memWdataR   <= memWdataNextS;
         memWeR      <= (nextStateS == WR);
         respValidR  <= (nextStateS == RESP);
         misalignedR <= acceptS && reqMisS;
         respRdataR  <= respRdataNextS;
      end
   end

   assign req_ready  = (stateR == IDLE);
   assign resp_valid = respValidR;
   assign resp_rdata = respRdataR;
   assign misaligned = misalignedR;
   assign mem_addr   = memAddrR;
   assign mem_wdata  = memWdataR;
   // A reset arriving while in WR must not let the pending write reach the RAM.
   assign mem_we     = memWeR && !rst;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-addressed reference memory
// predicts every response; a monitor pops expectations when resp_valid rises.
module tb_data_mem_ctrl;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          req_ready;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          misaligned;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   memRdata;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .misaligned(misaligned), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(memRdata)
   );

   // Word RAM with one cycle read latency
   logic [31:0] ram [128];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[8:2]] <= mem_wdata;
      memRdata <= ram[mem_addr[8:2]];
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int unsigned weCount = 0;

   logic [31:0] expData [$];
   logic        expMis  [$];
   int unsigned expDue  [$];
   int unsigned expWe   [$];

   logic [7:0] modelMem [512];

   function automatic logic modelMis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic u);
      int b;
      logic [31:0] v;
      b = int'(a % 512);
      if (sz == 2'd0) begin
         v = 32'(modelMem[b]);
         if (!u && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = 32'(modelMem[b]) + 32'(modelMem[b+1]) * 32'd256;
         if (!u && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else begin
         v = 32'(modelMem[b]) + 32'(modelMem[b+1]) * 32'd256
           + 32'(modelMem[b+2]) * 32'd65536 + 32'(modelMem[b+3]) * 32'd16777216;
      end
      return v;
   endfunction

   task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int b;
      b = int'(a % 512);
      for (int i = 0; i < (1 << sz); i++) modelMem[b + i] = d[8*i +: 8];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkRam(input int idx, input logic [31:0] exp, input string name);
      chk(name, ram[idx], exp);
   endtask

   // Issue one request, holding it until accepted, and record the prediction.
   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      int waitCnt;
      int unsigned lat;
      logic m;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      waitCnt = 0;
      while (!req_ready && waitCnt < 40) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL acceptTimeout: req_ready=%0b after %0d cycles, required 1", req_ready, waitCnt);
         req_valid = 1'b0;
      end else begin
         m = modelMis(sz, a);
         lat = m ? 1 : (w ? ((sz == 2'd2) ? 2 : 4) : 3);
         expDue.push_back(cyc + 1 + lat);
         expMis.push_back(m);
         expWe.push_back(weCount);
         expData.push_back((m || w) ? 32'h0 : modelLoad(a, sz, u));
         if (w && !m) modelStore(a, sz, d);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_addr  = $urandom;
         req_wdata = $urandom;
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (expData.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drainPending", 32'(expData.size()), 32'd0);
      @(negedge clk);
   endtask

   // Monitor: pops an expectation on every response
   initial begin : monitor
      logic [31:0] eData;
      logic        eMis;
      int unsigned eDue;
      int unsigned eWe;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            weCount++;
            chk("memAddrAlign", 32'(mem_addr[1:0]), 32'd0);
         end
         if (resp_valid) begin
            if (expData.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedResp: resp_valid=1 rdata=0x%08h, required no response", resp_rdata);
            end else begin
               eData = expData.pop_front();
               eMis  = expMis.pop_front();
               eDue  = expDue.pop_front();
               eWe   = expWe.pop_front();
               chk("respRdata", resp_rdata, eData);
               chk("misaligned", 32'(misaligned), 32'(eMis));
               chk("latency", cyc + 1, eDue);
               if (eMis) chk("noWeOnMisaligned", weCount, eWe);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      logic        w, u;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < 128; i++) ram[i] = 32'h0;
      for (int i = 0; i < 512; i++) modelMem[i] = 8'h00;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rstReady", 32'(req_ready), 32'd1);
      chk("rstRespValid", 32'(resp_valid), 32'd0);
      chk("rstMisaligned", 32'(misaligned), 32'd0);
      chk("rstRdata", resp_rdata, 32'd0);
      chk("rstMemWe", 32'(mem_we), 32'd0);
      chk("rstMemAddr", 32'(mem_addr), 32'd0);
      chk("rstMemWdata", mem_wdata, 32'd0);
      rst = 1'b0;

      // word store then word load
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      waitIdle();
      checkRam(4, 32'hDEADBEEF, "ramWordStore");

      // byte read-modify-write and byte loads
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
      issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h123456A5);
      waitIdle();
      checkRam(4, 32'hA5223344, "ramByteRmw");
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

      // half store and half loads
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      issue(1'b1, 2'd1, 1'b0, 32'h22, 32'hCAFE8001);
      waitIdle();
      checkRam(8, 32'h80010000, "ramHalfRmw");
      issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
      issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);

      // misaligned accesses
      issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
      issue(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF);
      issue(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF);

      // address wrap-around
      issue(1'b1, 2'd2, 1'b0, 32'h00000204, 32'h12345678);
      issue(1'b0, 2'd2, 1'b0, 32'h00000004, 32'h0);
      waitIdle();
      checkRam(1, 32'h12345678, "ramWrap");

      // reset in the write cycle of a byte store
      issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
      waitIdle();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h33; req_wdata = 32'h000000EE;
      chk("rmwAcceptReady", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (!mem_we && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rmwReachedWr", 32'(mem_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abortMemWe", 32'(mem_we), 32'd0);
      chk("abortRespValid", 32'(resp_valid), 32'd0);
      chk("abortReady", 32'(req_ready), 32'd1);
      checkRam(12, 32'h11223344, "abortRamUnchanged");
      rst = 1'b0;
      repeat (6) @(negedge clk);
      issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
      waitIdle();

      // randomized traffic against the byte-level model
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
         issue(w, sz, u, a, $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      waitIdle();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 9, giving the data memory byte-address width.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The module SHALL have port req_valid, input, 1, processor load/store request.
REQ-005 The module SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-006 The module SHALL have port req_size, input, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 The module SHALL have port req_unsigned, input, 1, zero-extend loads when 1.
REQ-008 The module SHALL have port req_addr, input, 32, byte address.
REQ-009 The module SHALL have port req_wdata, input, 32, store data in the low bits.
REQ-010 The module SHALL have port req_ready, output, 1, high only when a request can be accepted.
REQ-011 The module SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 The module SHALL have port resp_rdata, output, 32, extended load data.
REQ-013 The module SHALL have port misaligned, output, 1, valid with resp_valid.
REQ-014 The module SHALL have port mem_we, output, 1, word write enable to the data RAM.
REQ-015 The module SHALL have port mem_addr, output, ADDR_W, RAM byte address with bits [1:0] = 00.
REQ-016 The module SHALL have port mem_wdata, output, 32, RAM write word.
REQ-017 The module SHALL have port mem_rdata, input, 32, RAM read word, valid one cycle after mem_addr is presented.

Function
REQ-018 The FSM SHALL have states IDLE, RD, CAP, WR, RESP; req_ready = (state == IDLE).
REQ-019 A request SHALL be accepted on an edge where req_valid && req_ready; addr, wdata, size, write and unsigned are captured.
REQ-020 While the FSM is busy, req_valid SHALL be ignored; the requester holds the request.
REQ-021 mem_addr SHALL be {captured addr[ADDR_W-1:2], 2'b00}; higher address bits are dropped, giving wrap-around.
REQ-022 A misaligned request SHALL go IDLE->RESP with no RAM access. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-023 A word store SHALL go IDLE->WR->RESP, with mem_we=1 and mem_wdata=wdata in WR.
REQ-024 A load SHALL go IDLE->RD->CAP->RESP.
- RD: address presented.
- CAP: mem_rdata registered.
REQ-025 A byte or half store SHALL go IDLE->RD->CAP->WR->RESP (read-modify-write).
- WR writes the captured word with only the addressed lane replaced.
REQ-026 Lanes SHALL be little-endian.
- Byte k = bits [8k+7:8k] with k = addr[1:0].
- Half = bits [31:16] if addr[1] else [15:0].
REQ-027 Load extraction SHALL sign-extend from bit 7 or bit 15 unless req_unsigned=1 (zero-extend); word loads pass unchanged.
REQ-028 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- resp_rdata = extracted data for loads, 0 for stores and misaligned.
REQ-029 Latency from accept edge N to resp_valid SHALL be: misaligned N+1, word store N+2, load N+3, sub-word store N+4.
REQ-030 mem_we SHALL be asserted only in WR and never for misaligned requests.

Reset
REQ-031 On any edge with rst=1, state SHALL become IDLE and the following SHALL take effect from the next cycle:
- req_ready=1
- resp_valid=0, misaligned=0, resp_rdata=0
- mem_we=0, mem_addr=0, mem_wdata=0
REQ-032 A reset mid-operation SHALL abandon the access with no response and no further RAM write; rst takes priority over a simultaneous req_valid.

Verification
REQ-033 Word store/load: store 0xDEADBEEF to 0x10, then load word 0x10 -> resp_rdata=0xDEADBEEF at N+3, misaligned=0.
REQ-034 Byte RMW: word 0x11223344 at 0x10, store byte 0xA5 to 0x13 -> RAM 0xA5223344; lb 0x13 -> 0xFFFFFFA5; lbu -> 0x000000A5.
REQ-035 Half store: word 0 at 0x20, store half 0x8001 to 0x22 -> RAM 0x80010000; lh -> 0xFFFF8001; lhu -> 0x00008001.
REQ-036 Misaligned: load word 0x06 -> resp_valid at N+1, misaligned=1, resp_rdata=0, mem_we never high.
REQ-037 Reset during WR of a byte store -> mem_we low after the edge, no resp_valid, RAM word unchanged, req_ready=1.
REQ-038 Wrap: with ADDR_W=9, store 0x12345678 to 0x00000204, then load 0x004 -> 0x12345678.
